dmem_scheduler: RTL and testbench
=================================

DMEM_SCHEDULER -- requirements
Module: dmem_scheduler

Interface
REQ-001 SHALL have parameter SIZE, default 12, byte-address width of the shared memory (4 KiB).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports if_req in 1 (fetch request), if_addr in 32 (fetch byte address), if_gnt out 1 (request accepted), if_rvalid out 1 (read data valid), if_rdata out 32 (fetched word).
REQ-005 SHALL have ports ls_req in 1, ls_ctrl in 3 (000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW), ls_addr in 32, ls_wdata in 32, ls_gnt out 1, ls_rvalid out 1 (completion), ls_rdata out 32, ls_err out 1 (misaligned).
REQ-006 SHALL have ports mem_addr out SIZE-2 (word address), mem_we out 1, mem_wdata out 32, mem_rdata in 32 (synchronous single-port RAM, data valid one cycle after address).

Function
REQ-007 SHALL implement FSM states IDLE, READ, RMW, ACK.
REQ-008 Requesters SHALL hold req and attributes stable until gnt; the block SHALL register ctrl, addr[1:0], wdata and requester ID in the grant cycle.
REQ-009 Grant SHALL only occur in IDLE, combinationally in the same cycle as req; at most one gnt per cycle.
REQ-010 Priority: LSU over fetch, except when streak==2 and if_req=1, then fetch wins.
REQ-011 streak (2-bit) SHALL increment, saturating at 2, on each LSU grant with if_req=1; clear on fetch grant or whenever if_req=0.
REQ-012 mem_addr SHALL be addr[SIZE-1:2] of the granted request in the grant cycle; bits above SIZE-1 ignored.
REQ-013 Fetch/load grant: mem_we=0, IDLE->READ; in READ, rvalid=1 for the owner with formatted data, READ->IDLE.
REQ-014 Load formatting: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LB/LH replicate the sign bit into all upper bits; LBU/LHU zero-fill; LW passes the word; fetch always passes the word.
REQ-015 SW grant: mem_we=1, mem_wdata=ls_wdata in the grant cycle, IDLE->ACK; in ACK, ls_rvalid=1, ls_rdata=0, ACK->IDLE.
REQ-016 SB/SH grant: read issued, IDLE->RMW; in RMW, mem_addr held, mem_we=1, mem_wdata=mem_rdata with the target lane replaced by wdata[7:0]/wdata[15:0], ls_rvalid=1, RMW->IDLE.
REQ-017 Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): gnt=1, mem_we=0, IDLE->ACK; in ACK, ls_rvalid=1, ls_err=1, ls_rdata=0; memory unchanged.
REQ-018 ls_err SHALL be 0 except in REQ-017 ACK; rvalid SHALL be single-cycle pulses.
REQ-019 Every access occupies exactly 2 cycles; a new grant is possible in the cycle after completion.
REQ-020 rdata SHALL be 0 whenever the matching rvalid is 0.
REQ-021 mem_we SHALL be 1 only in an SW grant cycle or in RMW.

Reset
REQ-022 On rst: state=IDLE, streak=0, all outputs 0 (mem_addr, mem_we, mem_wdata, gnts, rvalids, rdatas, ls_err) immediately, without waiting for clk.
REQ-023 rst asserted in RMW or ACK SHALL abandon the operation: no write, no rvalid after release.
REQ-024 After rst deasserts, the first rising edge with a request SHALL behave as from IDLE.

Verification
REQ-025 Mem word 3 = 0x8000_0080; LB at 0x00C then LBU at 0x00C -> ls_rdata 0xFFFF_FF80 then 0x0000_0080, each rvalid 1 cycle after gnt.
REQ-026 Word 5 = 0x1122_3344; SB wdata 0xAA at 0x016 -> mem_we only in RMW, word becomes 0x11AA_3344, ls_rvalid in RMW cycle.
REQ-027 if_req and ls_req held high continuously -> grant sequence LSU, LSU, fetch, LSU, LSU, fetch.
REQ-028 LW at 0x002 -> ls_gnt, next cycle ls_rvalid=1, ls_err=1, ls_rdata=0, mem_we never 1.
REQ-029 rst asserted during RMW of SH at 0x020 -> mem_we drops asynchronously, word 8 unchanged, no ls_rvalid after release.
REQ-030 Fetch at 0x0000_1004 with SIZE=12 -> mem_addr=1, if_rdata=word 1.

Source files
------------

// File: rtl/dmem_scheduler.sv
// dmem_scheduler
// Arbitrates a single-port synchronous data memory between an instruction
// fetch port and a load/store port. Every access takes two cycles: a grant
// cycle (address, and the write for word stores) followed by one completion
// cycle (read data, read-modify-write for byte/half stores, or an ack).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr           fetch request and byte address
//   if_gnt/if_rvalid/if_rdata   fetch grant, read valid pulse, fetched word
//   ls_req/ls_ctrl/ls_addr/ls_wdata   load/store request, op, address, data
//   ls_gnt/ls_rvalid/ls_rdata/ls_err  grant, completion pulse, load data, misaligned
//   mem_addr/mem_we/mem_wdata/mem_rdata   word-addressed RAM port (1-cycle read)
module dmem_scheduler #(
   parameter int SIZE = 12
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [31:0]     if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [31:0]     if_rdata,
   input  logic            ls_req,
   input  logic [2:0]      ls_ctrl,
   input  logic [31:0]     ls_addr,
   input  logic [31:0]     ls_wdata,
   output logic            ls_gnt,
   output logic            ls_rvalid,
   output logic [31:0]     ls_rdata,
   output logic            ls_err,
   output logic [SIZE-3:0] mem_addr,
   output logic            mem_we,
   output logic [31:0]     mem_wdata,
   input  logic [31:0]     mem_rdata
);

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b011;
   localparam logic [2:0] LHU = 3'b100;
   localparam logic [2:0] SB  = 3'b101;
   localparam logic [2:0] SH  = 3'b110;
   localparam logic [2:0] SW  = 3'b111;

   typedef enum logic [1:0] {IDLE, READ, RMW, ACK} state_t;

   state_t          state_reg, state_next;
   logic [1:0]      streak_reg, streak_next;
   logic            owner_reg, owner_next;      // 1 = load/store port owns the access
   logic            err_reg, err_next;
   logic [2:0]      ctrl_reg, ctrl_next;
   logic [1:0]      off_reg, off_next;
   logic [15:0]     wdata_reg, wdata_next;      // only the low half is needed for SB/SH
   logic [SIZE-3:0] waddr_reg, waddr_next;

   logic            pick_ls, pick_if, misaligned;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [31:0]     load_data;
   logic [31:0]     merged;
   logic [3:0]      lane_hit;
   logic            unused_addr_bits;

   // Address bits outside the memory window and the fetch byte offset are ignored.
   assign unused_addr_bits = ^{if_addr[31:SIZE], if_addr[1:0], ls_addr[31:SIZE]};

   // Fetch overrides the load/store port only after two consecutive LSU wins
   // while fetch was waiting.
   assign pick_ls = ls_req && !(streak_reg == 2'd2 && if_req);
   assign pick_if = if_req && !pick_ls;

   assign misaligned = ((ls_ctrl == LH || ls_ctrl == LHU || ls_ctrl == SH) && ls_addr[0])
                    || ((ls_ctrl == LW || ls_ctrl == SW) && (ls_addr[1:0] != 2'b00));

   // Load formatting from the registered op and byte offset.
   always_comb begin
      byte_sel = mem_rdata[7:0];
      case (off_reg)
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         2'd3:    byte_sel = mem_rdata[31:24];
         default: byte_sel = mem_rdata[7:0];
      endcase
      half_sel = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (ctrl_reg)
         LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
         LH:      load_data = {{16{half_sel[15]}}, half_sel};
         LBU:     load_data = {24'd0, byte_sel};
         LHU:     load_data = {16'd0, half_sel};
         default: load_data = mem_rdata;
      endcase
   end

   // Read-modify-write merge: each byte lane takes store data when targeted.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_hit[gi] = (ctrl_reg == SB) ? (off_reg == 2'(gi))
                                                : (off_reg[1] == 1'(gi / 2));
         assign merged[8*gi +: 8] = !lane_hit[gi]     ? mem_rdata[8*gi +: 8] :
                                    (ctrl_reg == SB)  ? wdata_reg[7:0]       :
                                                        wdata_reg[8*(gi%2) +: 8];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         streak_reg <= 2'd0;
         owner_reg  <= 1'b0;
         err_reg    <= 1'b0;
         ctrl_reg   <= 3'd0;
         off_reg    <= 2'd0;
         wdata_reg  <= 16'd0;
         waddr_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         streak_reg <= streak_next;
         owner_reg  <= owner_next;
         err_reg    <= err_next;
         ctrl_reg   <= ctrl_next;
         off_reg    <= off_next;
         wdata_reg  <= wdata_next;
         waddr_reg  <= waddr_next;
      end
   end

   // Outputs are forced to zero while rst is high so reset takes effect
   // without waiting for a clock edge (this also kills an in-flight RMW write).
   always_comb begin
      state_next  = state_reg;
      streak_next = streak_reg;
      owner_next  = owner_reg;
      err_next    = err_reg;
      ctrl_next   = ctrl_reg;
      off_next    = off_reg;
      wdata_next  = wdata_reg;
      waddr_next  = waddr_reg;
      if_gnt      = 1'b0;
      if_rvalid   = 1'b0;
      if_rdata    = 32'd0;
      ls_gnt      = 1'b0;
      ls_rvalid   = 1'b0;
      ls_rdata    = 32'd0;
      ls_err      = 1'b0;
      mem_addr    = '0;
      mem_we      = 1'b0;
      mem_wdata   = 32'd0;
      if (!rst) begin
         case (state_reg)
            IDLE: begin
               if (pick_ls) begin
                  ls_gnt     = 1'b1;
                  mem_addr   = ls_addr[SIZE-1:2];
                  owner_next = 1'b1;
                  err_next   = misaligned;
                  ctrl_next  = ls_ctrl;
                  off_next   = ls_addr[1:0];
                  wdata_next = ls_wdata[15:0];
                  waddr_next = ls_addr[SIZE-1:2];
                  if (misaligned) begin
                     state_next = ACK;
                  end else if (ls_ctrl == SW) begin
                     mem_we     = 1'b1;
                     mem_wdata  = ls_wdata;
                     state_next = ACK;
                  end else if (ls_ctrl == SB || ls_ctrl == SH) begin
                     state_next = RMW;
                  end else begin
                     state_next = READ;
                  end
               end else if (pick_if) begin
                  if_gnt     = 1'b1;
                  mem_addr   = if_addr[SIZE-1:2];
                  owner_next = 1'b0;
                  state_next = READ;
               end
            end
            READ: begin
               if (owner_reg) begin
                  ls_rvalid = 1'b1;
                  ls_rdata  = load_data;
               end else begin
                  if_rvalid = 1'b1;
                  if_rdata  = mem_rdata;
               end
               state_next = IDLE;
            end
            RMW: begin
               mem_addr   = waddr_reg;
               mem_we     = 1'b1;
               mem_wdata  = merged;
               ls_rvalid  = 1'b1;
               state_next = IDLE;
            end
            ACK: begin
               ls_rvalid  = 1'b1;
               ls_err     = err_reg;
               state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
         // Count LSU wins that made a waiting fetch lose; any idle fetch cycle resets it.
         if (!if_req)
            streak_next = 2'd0;
         else if (ls_gnt)
            streak_next = (streak_reg == 2'd2) ? 2'd2 : streak_reg + 2'd1;
         else if (if_gnt)
            streak_next = 2'd0;
      end
   end

endmodule

// File: tb/tb_dmem_scheduler.sv
// tb_dmem_scheduler
// Directed bench for dmem_scheduler: a behavioural single-port RAM with a
// one-cycle registered read sits on the memory port, plus a backdoor write
// port used only while the scheduler is held in reset to preload words.
module tb_dmem_scheduler;
   localparam int SIZE = 12;
   localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3;
   localparam logic [2:0] LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

   logic        clk, rst;
   logic        if_req, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        ls_req, ls_gnt, ls_rvalid, ls_err;
   logic [2:0]  ls_ctrl;
   logic [31:0] ls_addr, ls_wdata, ls_rdata;
   logic [9:0]  mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata, mem_rdata;

   logic [31:0] ram [0:1023];
   logic        bk_we;
   logic [9:0]  bk_addr;
   logic [31:0] bk_data;

   int total = 0;
   int bad = 0;

   dmem_scheduler #(.SIZE(SIZE)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_ctrl(ls_ctrl), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else if (bk_we) ram[bk_addr] <= bk_data;
      mem_rdata <= ram[mem_addr];
   end

   task automatic poke(input logic [9:0] a, input logic [31:0] d);
      bk_we = 1'b1; bk_addr = a; bk_data = d;
      @(negedge clk);
      bk_we = 1'b0;
   endtask

   // One LSU transaction starting at a negedge in IDLE; returns at the negedge
   // of the cycle after completion. Samples grant-cycle and completion-cycle outputs.
   task automatic ls_access(input logic [2:0] c, input logic [31:0] a, input logic [31:0] wd,
                            output logic g, output logic [9:0] ma, output logic we0,
                            output logic [31:0] wd0, output logic rv, output logic [31:0] rd,
                            output logic er, output logic we1);
      ls_req = 1'b1; ls_ctrl = c; ls_addr = a; ls_wdata = wd;
      #1;
      g = ls_gnt; ma = mem_addr; we0 = mem_we; wd0 = mem_wdata;
      @(negedge clk);
      ls_req = 1'b0;
      #1;
      rv = ls_rvalid; rd = ls_rdata; er = ls_err; we1 = mem_we;
      @(negedge clk);
      $display("ls ctrl=%0d addr=%h wdata=%h gnt=%b rvalid=%b rdata=%h err=%b",
               c, a, wd, g, rv, rd, er);
   endtask

   task automatic test_reset;
      rst = 1'b1; bk_we = 1'b0;
      if_req = 1'b1; if_addr = 32'h4; ls_req = 1'b1; ls_ctrl = SW;
      ls_addr = 32'h10; ls_wdata = 32'hFFFF_FFFF;
      #1;
      total++; if ({if_gnt, ls_gnt, mem_we, if_rvalid, ls_rvalid, ls_err} !== 6'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=000000", {if_gnt, ls_gnt, mem_we, if_rvalid, ls_rvalid, ls_err}); end
      total++; if (mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin
         bad++; $display("FAIL reset_mem got=%h/%h exp=0/0", mem_addr, mem_wdata); end
      total++; if (if_rdata !== 32'd0 || ls_rdata !== 32'd0) begin
         bad++; $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata, ls_rdata); end
      $display("reset held with both requests high");
      if_req = 1'b0; ls_req = 1'b0;
      @(negedge clk);
      poke(10'd1, 32'h0BAD_F00D);
      poke(10'd3, 32'h8000_0080);
      poke(10'd5, 32'h1122_3344);
      poke(10'd6, 32'hDEAD_BEEF);
      poke(10'd7, 32'h0000_0000);
      poke(10'd8, 32'h5566_7788);
      rst = 1'b0;
   endtask

   task automatic test_loads;
      logic g, we0, rv, er, we1; logic [9:0] ma; logic [31:0] wd0, rd;
      ls_access(LB, 32'h00C, 32'h0, g, ma, we0, wd0, rv, rd, er, we1);
      total++; if (g !== 1'b1 || ma !== 10'd3 || we0 !== 1'b0) begin
         bad++; $display("FAIL lb_grant got=%b/%h/%b exp=1/003/0", g, ma, we0); end
      total++; if (rv !== 1'b1 || rd !== 32'hFFFF_FF80 || er !== 1'b0) begin
         bad++; $display("FAIL lb_data got=%b/%h/%b exp=1/ffffff80/0", rv, rd, er); end
      ls_access(LBU, 32'h00C, 32'h0, g, ma, we0, wd0, rv, rd, er, we1);
      total++; if (g !== 1'b1 || rv !== 1'b1 || rd !== 32'h0000_0080) begin
         bad++; $display("FAIL lbu_data got=%b/%b/%h exp=1/1/00000080", g, rv, rd); end
      ls_access(LH, 32'h00E, 32'h0, g, ma, we0, wd0, rv, rd, er, we1);
      total++; if (rv !== 1'b1 || rd !== 32'hFFFF_8000) begin
         bad++; $display("FAIL lh_data got=%b/%h exp=1/ffff8000", rv, rd); end
      ls_access(LHU, 32'h00E, 32'h0, g, ma, we0, wd0, rv, rd, er, we1);
      total++; if (rv !== 1'b1 || rd !== 32'h0000_8000) begin
         bad++; $display("FAIL lhu_data got=%b/%h exp=1/00008000", rv, rd); end
      ls_access(LB, 32'h017, 32'h0, g, ma, we0, wd0, rv, rd, er, we1);
      total++; if (rd !== 32'h0000_0011) begin
         bad++; $display("FAIL lb_byte3 got=%h exp=00000011", rd); end
      // pulse is single-cycle and data returns to zero
      #1;
      total++; if (ls_rvalid !== 1'b0 || ls_rdata !== 32'd0) begin
         bad++; $display("FAIL rvalid_pulse got=%b/%h exp=0/0", ls_rvalid, ls_rdata); end
      @(negedge clk);
   endtask

   task automatic test_stores;
      logic g, we0, rv, er, we1; logic [9:0] ma; logic [31:0] wd0, rd;
      ls_access(SB, 32'h016, 32'h0000_00AA, g, ma, we0, wd0, rv, rd, er, we1);
      total++; if (g !== 1'b1 || ma !== 10'd5 || we0 !== 1'b0) begin
         bad++; $display("FAIL sb_grant got=%b/%h/%b exp=1/005/0", g, ma, we0); end
      total++; if (we1 !== 1'b1 || rv !== 1'b1 || er !== 1'b0) begin
         bad++; $display("FAIL sb_rmw got=%b/%b/%b exp=1/1/0", we1, rv, er); end
      total++; if (ram[5] !== 32'h11AA_3344) begin
         bad++; $display("FAIL sb_word got=%h exp=11aa3344", ram[5]); end
      ls_access(SH, 32'h01A, 32'hFFFF_1234, g, ma, we0, wd0, rv, rd, er, we1);
      total++; if (ram[6] !== 32'h1234_BEEF || we1 !== 1'b1) begin
         bad++; $display("FAIL sh_word got=%h/%b exp=1234beef/1", ram[6], we1); end
      ls_access(SW, 32'h01C, 32'hCAFE_BABE, g, ma, we0, wd0, rv, rd, er, we1);
      total++; if (we0 !== 1'b1 || wd0 !== 32'hCAFE_BABE || ma !== 10'd7) begin
         bad++; $display("FAIL sw_grant got=%b/%h/%h exp=1/cafebabe/007", we0, wd0, ma); end
      total++; if (rv !== 1'b1 || rd !== 32'd0 || we1 !== 1'b0 || er !== 1'b0) begin
         bad++; $display("FAIL sw_ack got=%b/%h/%b/%b exp=1/0/0/0", rv, rd, we1, er); end
      ls_access(LW, 32'h01C, 32'h0, g, ma, we0, wd0, rv, rd, er, we1);
      total++; if (rd !== 32'hCAFE_BABE) begin
         bad++; $display("FAIL sw_readback got=%h exp=cafebabe", rd); end
   endtask

   task automatic test_misaligned;
      logic g, we0, rv, er, we1; logic [9:0] ma; logic [31:0] wd0, rd;
      ls_access(LW, 32'h002, 32'h0, g, ma, we0, wd0, rv, rd, er, we1);
      total++; if (g !== 1'b1 || we0 !== 1'b0 || we1 !== 1'b0) begin
         bad++; $display("FAIL lw_mis_grant got=%b/%b/%b exp=1/0/0", g, we0, we1); end
      total++; if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'd0) begin
         bad++; $display("FAIL lw_mis_ack got=%b/%b/%h exp=1/1/0", rv, er, rd); end
      ls_access(SH, 32'h021, 32'h0000_FFFF, g, ma, we0, wd0, rv, rd, er, we1);
      total++; if (er !== 1'b1 || we1 !== 1'b0 || ram[8] !== 32'h5566_7788) begin
         bad++; $display("FAIL sh_mis got=%b/%b/%h exp=1/0/55667788", er, we1, ram[8]); end
      ls_access(LHU, 32'h00F, 32'h0, g, ma, we0, wd0, rv, rd, er, we1);
      total++; if (er !== 1'b1 || rd !== 32'd0) begin
         bad++; $display("FAIL lhu_mis got=%b/%h exp=1/0", er, rd); end
      #1;
      total++; if (ls_err !== 1'b0) begin
         bad++; $display("FAIL err_clear got=%b exp=0", ls_err); end
      @(negedge clk);
   endtask

   task automatic test_fetch;
      if_req = 1'b1; if_addr = 32'h0000_1004;
      #1;
      total++; if (if_gnt !== 1'b1 || ls_gnt !== 1'b0 || mem_addr !== 10'd1 || mem_we !== 1'b0) begin
         bad++; $display("FAIL fetch_grant got=%b/%b/%h/%b exp=1/0/001/0", if_gnt, ls_gnt, mem_addr, mem_we); end
      @(negedge clk);
      if_req = 1'b0;
      #1;
      total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h0BAD_F00D || ls_rvalid !== 1'b0) begin
         bad++; $display("FAIL fetch_data got=%b/%h/%b exp=1/0badf00d/0", if_rvalid, if_rdata, ls_rvalid); end
      @(negedge clk);
      #1;
      total++; if (if_rvalid !== 1'b0 || if_rdata !== 32'd0) begin
         bad++; $display("FAIL fetch_idle got=%b/%h exp=0/0", if_rvalid, if_rdata); end
      $display("fetch addr=00001004 rdata=0badf00d");
      @(negedge clk);
   endtask

   task automatic test_priority;
      logic [1:0] exp_seq [12];
      logic [1:0] obs;
      exp_seq = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00,
                  2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      if_req = 1'b1; if_addr = 32'h0000_1004;
      ls_req = 1'b1; ls_ctrl = LW; ls_addr = 32'h00C; ls_wdata = 32'h0;
      for (int i = 0; i < 12; i++) begin
         #1;
         obs = {if_gnt, ls_gnt};
         total++; if (obs !== exp_seq[i]) begin
            bad++; $display("FAIL prio_cycle%0d got=%b exp=%b", i, obs, exp_seq[i]); end
         if (obs != 2'b00) $display("grant cycle=%0d if_gnt=%b ls_gnt=%b", i, obs[1], obs[0]);
         @(negedge clk);
      end
      if_req = 1'b0; ls_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_rmw;
      logic g, we0, rv, er, we1; logic [9:0] ma; logic [31:0] wd0, rd;
      ls_req = 1'b1; ls_ctrl = SH; ls_addr = 32'h020; ls_wdata = 32'h0000_ABCD;
      #1;
      total++; if (ls_gnt !== 1'b1) begin
         bad++; $display("FAIL rmw_rst_grant got=%b exp=1", ls_gnt); end
      @(negedge clk);
      ls_req = 1'b0;
      #1;
      total++; if (mem_we !== 1'b1) begin
         bad++; $display("FAIL rmw_rst_we_before got=%b exp=1", mem_we); end
      rst = 1'b1;
      #1;
      total++; if (mem_we !== 1'b0 || ls_rvalid !== 1'b0 || mem_wdata !== 32'd0) begin
         bad++; $display("FAIL rmw_rst_async got=%b/%b/%h exp=0/0/0", mem_we, ls_rvalid, mem_wdata); end
      @(negedge clk);
      rst = 1'b0;
      $display("reset during SH rmw addr=00000020");
      for (int i = 0; i < 2; i++) begin
         #1;
         total++; if (ls_rvalid !== 1'b0) begin
            bad++; $display("FAIL rmw_rst_norvalid%0d got=%b exp=0", i, ls_rvalid); end
         @(negedge clk);
      end
      total++; if (ram[8] !== 32'h5566_7788) begin
         bad++; $display("FAIL rmw_rst_word got=%h exp=55667788", ram[8]); end
      ls_access(LW, 32'h00C, 32'h0, g, ma, we0, wd0, rv, rd, er, we1);
      total++; if (g !== 1'b1 || rv !== 1'b1 || rd !== 32'h8000_0080) begin
         bad++; $display("FAIL post_reset_lw got=%b/%b/%h exp=1/1/80000080", g, rv, rd); end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_loads();
      test_stores();
      test_misaligned();
      test_fetch();
      test_priority();
      test_reset_rmw();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
